// File: rtl/tlb_write_unit_if.sv
// tlb_write_unit_if: CP0 command handshake and result bundle.
// master = CP0 side, slave = tlb_write_unit.
interface tlb_write_unit_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [31:0] entry_hi_i;
   logic [31:0] entry_lo0_i;
   logic [31:0] entry_lo1_i;
   logic [3:0]  index_i;
   logic        done_o;
   logic [31:0] probe_index_o;
   logic [31:0] rd_entry_hi_o;
   logic [31:0] rd_entry_lo0_o;
   logic [31:0] rd_entry_lo1_o;

   modport master (
      output cmd_valid_i,
      output cmd_op_i,
      output entry_hi_i,
      output entry_lo0_i,
      output entry_lo1_i,
      output index_i,
      input  cmd_ready_o,
      input  done_o,
      input  probe_index_o,
      input  rd_entry_hi_o,
      input  rd_entry_lo0_o,
      input  rd_entry_lo1_o
   );

   modport slave (
      input  cmd_valid_i,
      input  cmd_op_i,
      input  entry_hi_i,
      input  entry_lo0_i,
      input  entry_lo1_i,
      input  index_i,
      output cmd_ready_o,
      output done_o,
      output probe_index_o,
      output rd_entry_hi_o,
      output rd_entry_lo0_o,
      output rd_entry_lo1_o
   );
endinterface

// File: rtl/tlb_write_unit.sv
// tlb_write_unit: TLB storage plus TLBR/TLBWI/TLBWR/TLBP engine and Random.
// Define TLB_PARALLEL_PROBE_EN for single-cycle TLBP; default probes serially.
module tlb_write_unit #(
   parameter int TLB_ENTRY_NUM   = 16,
   parameter int TLB_ENTRY_WIDTH = 96
) (
   input  logic clk,
   input  logic rst_n,
   tlb_write_unit_if.slave cmd,
   input  logic [3:0] wired_i,
   input  logic wired_we_i,
   output logic [TLB_ENTRY_NUM*TLB_ENTRY_WIDTH-1:0] entries_o,
   output logic [3:0] random_o
);

   localparam logic [1:0] OP_TLBR  = 2'b00;
   localparam logic [1:0] OP_TLBWI = 2'b01;
   localparam logic [1:0] OP_TLBWR = 2'b10;
   localparam logic [1:0] OP_TLBP  = 2'b11;
   localparam logic [31:0] PROBE_MISS = 32'h8000_0000;

`ifdef TLB_PARALLEL_PROBE_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;
`endif

   typedef logic [TLB_ENTRY_WIDTH-1:0] entry_t;

   entry_t      ent_q [TLB_ENTRY_NUM];
   logic [3:0]  random_q;
   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic        is_read;
   logic        is_write;
   logic        is_probe;
   logic [3:0]  wr_idx;
   entry_t      wr_ent;
   entry_t      rd_ent;
   logic        probe_hit;
   logic [3:0]  probe_idx;
   logic        probe_commit;
   logic [31:0] probe_result;
   logic [31:0] probe_idx_q;
   logic [31:0] rd_hi_q;
   logic [31:0] rd_lo0_q;
   logic [31:0] rd_lo1_q;

   function automatic entry_t pack_entry(
      input logic [31:0] hi,
      input logic [31:0] lo0,
      input logic [31:0] lo1
   );
      entry_t e;
      e        = '0;
      e[7:0]   = hi[7:0];
      e[31:13] = hi[31:13];
      e[32]    = lo0[0] & lo1[0];
      e[33]    = lo0[1];
      e[34]    = lo0[2];
      e[37:35] = lo0[5:3];
      e[57:38] = lo0[25:6];
      e[65]    = lo1[1];
      e[66]    = lo1[2];
      e[69:67] = lo1[5:3];
      e[89:70] = lo1[25:6];
      return e;
   endfunction

   // Global entries ignore the ASID.
   function automatic logic tlb_match(
      input entry_t e,
      input logic [31:0] hi
   );
      return (e[31:13] == hi[31:13]) &&
             ((e[7:0] == hi[7:0]) || e[32]);
   endfunction

   assign accept = cmd.cmd_valid_i && (state_q == IDLE);

   always_comb begin
      is_read  = 1'b0;
      is_write = 1'b0;
      is_probe = 1'b0;
      wr_idx   = cmd.index_i;
      unique case (cmd.cmd_op_i)
         OP_TLBR:  is_read  = 1'b1;
         OP_TLBWI: is_write = 1'b1;
         OP_TLBWR: begin
            is_write = 1'b1;
            wr_idx   = random_q;
         end
         OP_TLBP:  is_probe = 1'b1;
         default:  ;
      endcase
   end

   assign wr_ent = pack_entry(cmd.entry_hi_i,
                              cmd.entry_lo0_i,
                              cmd.entry_lo1_i);
   assign rd_ent = ent_q[cmd.index_i];

`ifdef TLB_PARALLEL_PROBE_EN
   // Walk downward so the lowest matching index is the final winner.
   always_comb begin
      probe_hit = 1'b0;
      probe_idx = '0;
      for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
         if (tlb_match(ent_q[i], cmd.entry_hi_i)) begin
            probe_hit = 1'b1;
            probe_idx = i[3:0];
         end
      end
   end

   assign probe_commit = accept && is_probe;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
`else
   logic [3:0]  scan_idx_q;
   logic [31:0] probe_key_q;
   logic        scan_last;

   assign probe_hit = tlb_match(ent_q[scan_idx_q], probe_key_q);
   assign probe_idx = scan_idx_q;
   assign scan_last = (scan_idx_q == 4'(TLB_ENTRY_NUM - 1));
   assign probe_commit = (state_q == SCAN) && (probe_hit || scan_last);

   // EntryHi is captured so CP0 may change it mid-scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx_q  <= '0;
         probe_key_q <= '0;
      end else if (accept && is_probe) begin
         scan_idx_q  <= '0;
         probe_key_q <= cmd.entry_hi_i;
      end else if (state_q == SCAN) begin
         scan_idx_q  <= scan_idx_q + 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = is_probe ? SCAN : RESP;
         end
         SCAN:    if (probe_commit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
`endif

   assign probe_result = probe_hit ? {28'b0, probe_idx} : PROBE_MISS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TLB_ENTRY_NUM; i++) ent_q[i] <= '0;
         rd_hi_q     <= '0;
         rd_lo0_q    <= '0;
         rd_lo1_q    <= '0;
         probe_idx_q <= '0;
      end else begin
         if (accept && is_write) ent_q[wr_idx] <= wr_ent;
         if (accept && is_read) begin
            rd_hi_q  <= {rd_ent[31:13], 5'b0, rd_ent[7:0]};
            rd_lo0_q <= {6'b0, rd_ent[57:38], rd_ent[37:35],
                         rd_ent[34], rd_ent[33], rd_ent[32]};
            rd_lo1_q <= {6'b0, rd_ent[89:70], rd_ent[69:67],
                         rd_ent[66], rd_ent[65], rd_ent[32]};
         end
         if (probe_commit) probe_idx_q <= probe_result;
      end
   end

   // Random wraps to the top once it reaches the wired boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         random_q <= 4'hF;
      else if (wired_we_i || (random_q <= wired_i))
         random_q <= 4'hF;
      else
         random_q <= random_q - 4'd1;
   end

   for (genvar g = 0; g < TLB_ENTRY_NUM; g++) begin : g_flat
      assign entries_o[g*TLB_ENTRY_WIDTH +: TLB_ENTRY_WIDTH] = ent_q[g];
   end

   assign random_o           = random_q;
   assign cmd.cmd_ready_o    = (state_q == IDLE);
   assign cmd.done_o         = (state_q == RESP);
   assign cmd.probe_index_o  = probe_idx_q;
   assign cmd.rd_entry_hi_o  = rd_hi_q;
   assign cmd.rd_entry_lo0_o = rd_lo0_q;
   assign cmd.rd_entry_lo1_o = rd_lo1_q;

endmodule

// File: doc/tlb_write_unit.md
# tlb_write_unit

Owns the TLB entry storage and executes the four CP0 TLB instructions (TLBR, TLBWI, TLBWR, TLBP) against it. Drives the flattened entry vector consumed by the instruction- and data-side lookup blocks, maintains the CP0 Random register, and returns read-back and probe results to CP0 through a valid/ready command handshake with a done pulse.

## Interface
- `TLB_ENTRY_NUM`, 16: number of entries; index width is 4.
- `TLB_ENTRY_WIDTH`, 96: bits per packed entry in `entries_o`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: **asynchronous, active-low** reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: block is idle and can accept a command.
- `cmd_op_i` in 2: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
- `entry_hi_i` in 32: CP0 EntryHi (VPN2 [31:13], ASID [7:0]).
- `entry_lo0_i`, `entry_lo1_i` in 32 each: CP0 EntryLo (PFN [25:6], C [5:3], D [2], V [1], G [0]).
- `index_i` in 4: CP0 Index for TLBR/TLBWI.
- `wired_i` in 4: CP0 Wired.
- `wired_we_i` in 1: CP0 writing Wired this cycle.
- `entries_o` out `TLB_ENTRY_NUM*TLB_ENTRY_WIDTH`: packed entry storage.
- `random_o` out 4: CP0 Random.
- `done_o` out 1: one-cycle pulse, command complete; result outputs valid.
- `probe_index_o` out 32: TLBP result; bit 31 = P (miss), [3:0] = index, other bits 0.
- `rd_entry_hi_o`, `rd_entry_lo0_o`, `rd_entry_lo1_o` out 32 each: TLBR result.

## Operation
- Packed entry i at offset i*96: [7:0] ASID, [31:13] VPN2, [32] G, [33] V0, [34] D0, [37:35] C0, [57:38] PFN0, [65] V1, [66] D1, [69:67] C1, [89:70] PFN1; all other bits 0.
- Write (TLBWI to `index_i`, TLBWR to `random_o` sampled at accept): fields from inputs; G = lo0.G & lo1.G.
- TLBR: rd_entry_hi = {VPN2, 5'b0, ASID}; rd_entry_loN = {6'b0, PFNn, Cn, Dn, Vn, G}.
- TLBP match: VPN2 == entry_hi_i[31:13] and (ASID == entry_hi_i[7:0] or G). Multiple matches: lowest index wins. Miss: probe_index_o = 32'h8000_0000.
- FSM: IDLE (ready=1) → on accept: TLBR/TLBWI/TLBWR → RESP; TLBP → SCAN (serial) or RESP (parallel, see Configuration). SCAN compares entry `scan_idx` per cycle, starting at 0; on match or after index 15 → RESP. RESP: done_o=1, ready=0, → IDLE.
- Random: decrements every cycle; if random == wired_i, or random < wired_i, next = 15; wired_we_i forces next = 15 (highest priority). wired_i = 15 holds Random at 15. Runs independently of the FSM.
- Result outputs hold their last value until the next command of the same kind completes.

## Timing
- Reset values: entries_o all 0, random_o 15, cmd_ready_o 1, done_o 0, probe_index_o 0, rd_entry_* 0, FSM IDLE.
- Accept at edge N (valid & ready). Writes: entry updated at edge N, visible on entries_o in cycle N+1; done_o in cycle N+1.
- TLBR: rd_entry_* registered at edge N, done_o in cycle N+1.
- TLBP serial: entry k compared in cycle N+1+k; match at k → done_o in cycle N+2+k; miss → done_o in cycle N+17.
- Throughput: one command per 2 cycles minimum; cmd_valid_i ignored while ready=0.
- Reset asserted mid-SCAN/RESP: abort immediately, no done_o, all state to reset values.

## Configuration
- `TLB_PARALLEL_PROBE_EN` defined: TLBP compares all 16 entries combinationally in the accept cycle with lowest-index priority; result registered at edge N, done_o in cycle N+1; no SCAN state.
- Undefined: serial one-entry-per-cycle SCAN as above. Results (index, P bit) identical in both builds; only latency differs.

## Test plan
- Reset, then idle 20 cycles with wired_i=4 → random_o sequence 15,14,…,4,15,14…; entries_o all 0, ready=1.
- TLBWI index 3, hi=32'h0040_2005, lo0=32'h0000_1047, lo1=32'h0000_2087 → entry 3 VPN2=19'h201, ASID=8'h05, G=1, PFN0=20'h41, PFN1=20'h82; then TLBR index 3 → rd_entry_hi=32'h0040_2005, rd_entry_lo0=32'h0000_1047, rd_entry_lo1=32'h0000_2087.
- TLBP with hi=32'h0040_20FF after previous write → probe_index_o=32'h0000_0003 (G match despite ASID mismatch); serial done_o 5 cycles after accept.
- TLBP on empty-matching VPN2 → probe_index_o=32'h8000_0000, serial done_o 17 cycles after accept; same VPN2 in entries 5 and 9 → index 5.
- TLBWR with wired_i=8 over many writes → every written index in 8..15, entries 0..7 untouched; wired_we_i pulse → random_o=15 next cycle.
- Assert rst_n during SCAN → done_o never pulses, entries_o zeroed, ready=1 after release.
